riscv_v_bw_logic_unit: RTL
==========================

Name: riscv_v_bw_logic_unit

Overview:
Parametrised successor to the single-op vector bitwise blocks. It handles AND, OR and XOR in one unit, in two modes:
- Elementwise mode: one beat, registered result.
- Reduction mode: multi-beat accumulation across a register group (LMUL beats), then a multi-cycle halving fold down to the element width (SEW), then combination with the scalar seed.
It sits in the vector ALU beside the arithmetic units. It has valid/ready handshakes on input and output, so register-file read sequencing and writeback can stall it.

Parameters:
NUM_BYTES, 16, datapath width in bytes; power of 2, at least 8.
MAX_BEATS, 8, maximum beats per reduction (LMUL bound); power of 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_op  in  2  00 AND, 01 OR, 10 XOR; 11 reserved, treated as XOR
in_sew  in  2  element width: 00 8b, 01 16b, 10 32b, 11 64b
in_reduct  in  1  1 = reduction, 0 = elementwise
in_last  in  1  last beat of a reduction
in_is_mask  in  1  mask op; forces every byte valid
in_srca  in  8*NUM_BYTES  vector source (vs2)
in_srcb  in  8*NUM_BYTES  elementwise second operand, or seed (element 0 of vs1) on the first reduction beat
in_byte_valid  in  NUM_BYTES  per-byte valid
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_result  out  8*NUM_BYTES  result
out_byte_valid  out  NUM_BYTES  valid bytes of the result

Behaviour:
- Reset: synchronous, active-high, clk only. Clears out_valid, out_result, out_byte_valid, the accumulator and the beat counter, and sets state IDLE.
  - in_ready is 1 in the cycle after reset.
  - A partial reduction in flight is discarded.
- Byte valid: effective valid = in_byte_valid | in_is_mask.
- Accept and hold: a beat is accepted when in_valid & in_ready. While out_valid & ~out_ready, every output is held stable.
- FSM states: IDLE, ACCUM, FOLD, DONE.
- IDLE:
  - in_ready = ~out_valid | out_ready.
  - Elementwise beat accepted:
    - Next cycle: out_result = srca op srcb; out_byte_valid = effective valid; out_valid = 1.
    - Latency 1, throughput 1 beat per cycle under out_ready = 1.
    - State stays IDLE.
  - Reduction beat accepted:
    - Capture op, sew and the seed (the low SEW bits of srcb).
    - Initialise acc = identity op masked(srca).
    - beat_cnt = 1.
    - Go to ACCUM, or to FOLD if in_last = 1.
  - Masked(srca): bytes with effective valid = 0 are replaced by the identity.
  - Identity: 0xFF for AND; 0x00 for OR and XOR.
- ACCUM:
  - in_ready = 1.
  - On each accepted beat: acc = acc op masked(srca), beat_cnt++.
  - in_op and in_sew on non-first beats are ignored.
  - Leave for FOLD when in_last = 1, or when beat_cnt reaches MAX_BEATS (forced termination; in_last absent).
  - An elementwise beat (in_reduct = 0) in ACCUM is treated as a reduction beat.
- FOLD:
  - in_ready = 0.
  - Each cycle: acc low half = low half op high half; the active width halves.
  - F = log2(NUM_BYTES / sew_bytes) cycles, counted by a fold counter.
  - If F = 0 (SEW equals the datapath width), FOLD takes exactly 1 cycle, which applies the seed only.
  - The seed is applied in the last fold cycle.
  - Then go to DONE with out_valid = 1.
  - out_result holds the folded element in the low sew_bytes; upper bytes are 0. out_byte_valid has only the low sew_bytes bits set.
- DONE:
  - in_ready = out_ready.
  - On out_ready, go to IDLE.
  - A new beat accepted in the same cycle is processed as if from IDLE, so there is no bubble.
- Reduction latency: last beat accepted at cycle T gives out_valid at T + max(F, 1) + 1.
- Simultaneous events: rst has priority over all handshakes.

Decomposition:
- riscv_v_pkg gets:
  - a bw_op_t enum (BW_AND, BW_OR, BW_XOR);
  - a sew_t encoding;
  - a function bw_identity(bw_op_t) returning a byte;
  - a function sew_bytes(sew_t).
- Sub-module riscv_v_bw_lane_op: combinational, parametrised DATA_WIDTH, op-selected A op B. It is instanced for the accumulate path and again for the fold path.
- FSM and counters stay in the top module.

Test Plan:
All scenarios use NUM_BYTES = 16.
1. Elementwise XOR, srca all 0xAA, srcb all 0x0F, byte_valid 0xFFFF -> next cycle out_result all 0xA5, out_byte_valid 0xFFFF, out_valid 1. Back-to-back beats give 1 result per cycle.
2. Reduction OR, SEW 8, single beat with last:
   - srca byte3 = 0x10, byte9 = 0x01, all other bytes 0; seed byte0 = 0x80.
   - Expected: out_valid 5 cycles after accept (F = 4); out byte0 = 0x91, other bytes 0; out_byte_valid 0x0001.
3. Reduction AND, SEW 32, two beats:
   - Beat 1: srca all 0xFF except word1 = 0x0F0F0F0F.
   - Beat 2: byte_valid 0x00FF, invalid bytes = 0x00.
   - Seed = 0xFFFFFFFF.
   - Expected: result 0x0F0F0F0F (invalid bytes take the identity); out_byte_valid 0x000F.
4. Backpressure: hold out_ready = 0 for 3 cycles with out_valid = 1 -> out_result is stable and in_ready = 0 throughout; raising out_ready plus a new beat gives acceptance in the same cycle.
5. Assert rst in ACCUM after 2 beats -> next cycle out_valid = 0 and in_ready = 1; a following one-beat OR reduction gives only its own result.
6. Send 8 reduction beats with in_last = 0 -> forced fold after beat 8; beat 9 is held (in_ready = 0) until DONE is consumed.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector bitwise logic unit.
package riscv_v_pkg;

  typedef enum logic [1:0] {
    BW_AND = 2'b00,
    BW_OR  = 2'b01,
    BW_XOR = 2'b10
  } bw_op_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFold,
    StDone
  } bw_state_t;

  // The reserved encoding 2'b11 behaves as XOR.
  function automatic bw_op_t to_bw_op(logic [1:0] op);
    case (op)
      2'b00:   return BW_AND;
      2'b01:   return BW_OR;
      default: return BW_XOR;
    endcase
  endfunction

  function automatic logic [7:0] bw_identity(bw_op_t op);
    return (op == BW_AND) ? 8'hFF : 8'h00;
  endfunction

  function automatic int unsigned sew_bytes(sew_t sew);
    return 32'd1 << sew;
  endfunction

  function automatic logic [63:0] sew_mask64(sew_t sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_bw_lane_op.sv
// Combinational A op B over a parametrised width.
module riscv_v_bw_lane_op
  import riscv_v_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  bw_op_t                i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y
);

  always_comb begin
    case (i_op)
      BW_AND:  o_y = i_a & i_b;
      BW_OR:   o_y = i_a | i_b;
      default: o_y = i_a ^ i_b;
    endcase
  end

endmodule

// File: rtl/riscv_v_bw_logic_unit.sv
// Vector AND/OR/XOR unit: single-beat elementwise results, or multi-beat
// reductions folded down to SEW and combined with a scalar seed.
module riscv_v_bw_logic_unit
  import riscv_v_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [1:0]             in_sew,
  input  logic                   in_reduct,
  input  logic                   in_last,
  input  logic                   in_is_mask,
  input  logic [8*NUM_BYTES-1:0] in_srca,
  input  logic [8*NUM_BYTES-1:0] in_srcb,
  input  logic [NUM_BYTES-1:0]   in_byte_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_result,
  output logic [NUM_BYTES-1:0]   out_byte_valid
);

  localparam int unsigned W       = 8 * NUM_BYTES;
  localparam int unsigned LOG2_NB = $clog2(NUM_BYTES);
  localparam int unsigned CW      = $clog2(MAX_BEATS) + 1;
  localparam int unsigned FW      = $clog2(LOG2_NB + 1);

  bw_state_t           r_state;
  bw_op_t              r_op;
  sew_t                r_sew;
  logic [63:0]         r_seed;
  logic [W-1:0]        r_acc;
  logic [CW-1:0]       r_beat_cnt;
  logic [FW-1:0]       r_fold_left;
  logic [LOG2_NB-1:0]  r_half;
  logic                r_out_valid;
  logic [W-1:0]        r_out_result;
  logic [NUM_BYTES-1:0] r_out_bv;

  logic                 w_idle_like;
  logic                 w_accept;
  logic                 w_elem;
  bw_op_t               w_in_op;
  bw_op_t               w_acc_op;
  logic [7:0]           w_ident_byte;
  logic [NUM_BYTES-1:0] w_eff_bv;
  logic [W-1:0]         w_masked;
  logic [W-1:0]         w_lane_a;
  logic [W-1:0]         w_lane_b;
  logic [W-1:0]         w_acc_y;
  logic [W-1:0]         w_fold_b;
  logic [W-1:0]         w_fold_y;
  logic [63:0]          w_fold_src;
  logic [63:0]          w_seed_y;
  logic [W-1:0]         w_red_result;
  logic [NUM_BYTES-1:0] w_red_bv;
  logic [CW-1:0]        w_cnt_nxt;

  // DONE accepts a new beat exactly like IDLE, which removes the bubble.
  assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
  assign in_ready    = w_idle_like ? (~r_out_valid | out_ready) : (r_state == StAccum);
  assign w_accept    = in_valid & in_ready;
  assign w_elem      = w_idle_like & ~in_reduct;
  assign w_in_op     = to_bw_op(in_op);
  assign w_acc_op    = w_idle_like ? w_in_op : r_op;
  assign w_ident_byte = bw_identity(w_acc_op);
  assign w_eff_bv    = in_byte_valid | {NUM_BYTES{in_is_mask}};
  assign w_cnt_nxt   = r_beat_cnt + 1'b1;

  always_comb begin
    w_masked = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      w_masked[8*i +: 8] = w_eff_bv[i] ? in_srca[8*i +: 8] : w_ident_byte;
    end
  end

  assign w_lane_a = w_elem ? in_srca :
                    (w_idle_like ? {NUM_BYTES{w_ident_byte}} : r_acc);
  assign w_lane_b = w_elem ? in_srcb : w_masked;

  riscv_v_bw_lane_op #(.DATA_WIDTH(W)) u_acc_op (
    .i_op (w_acc_op),
    .i_a  (w_lane_a),
    .i_b  (w_lane_b),
    .o_y  (w_acc_y)
  );

  // Upper bits beyond the active half are don't-care; only the low sew bytes survive.
  assign w_fold_b = r_acc >> {r_half, 3'b000};

  riscv_v_bw_lane_op #(.DATA_WIDTH(W)) u_fold_op (
    .i_op (r_op),
    .i_a  (r_acc),
    .i_b  (w_fold_b),
    .o_y  (w_fold_y)
  );

  assign w_fold_src = (r_fold_left == '0) ? r_acc[63:0] : w_fold_y[63:0];

  riscv_v_bw_lane_op #(.DATA_WIDTH(64)) u_seed_op (
    .i_op (r_op),
    .i_a  (w_fold_src),
    .i_b  (r_seed),
    .o_y  (w_seed_y)
  );

  always_comb begin
    w_red_result       = '0;
    w_red_result[63:0] = w_seed_y & sew_mask64(r_sew);
    w_red_bv           = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      w_red_bv[i] = (i < sew_bytes(r_sew));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_op         <= BW_AND;
      r_sew        <= SEW_8;
      r_seed       <= '0;
      r_acc        <= '0;
      r_beat_cnt   <= '0;
      r_fold_left  <= '0;
      r_half       <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_bv     <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
          if (r_state == StDone && out_ready) r_state <= StIdle;
          if (w_accept) begin
            if (!in_reduct) begin
              r_out_valid  <= 1'b1;
              r_out_result <= w_acc_y;
              r_out_bv     <= w_eff_bv;
              r_state      <= StIdle;
            end else begin
              r_op        <= w_in_op;
              r_sew       <= sew_t'(in_sew);
              r_seed      <= in_srcb[63:0] & sew_mask64(sew_t'(in_sew));
              r_acc       <= w_acc_y;
              r_beat_cnt  <= CW'(1);
              r_fold_left <= FW'(LOG2_NB) - FW'(in_sew);
              r_half      <= LOG2_NB'(NUM_BYTES / 2);
              r_state     <= (in_last || MAX_BEATS == 1) ? StFold : StAccum;
            end
          end
        end
        StAccum: begin
          if (w_accept) begin
            r_acc      <= w_acc_y;
            r_beat_cnt <= w_cnt_nxt;
            if (in_last || w_cnt_nxt == CW'(MAX_BEATS)) r_state <= StFold;
          end
        end
        StFold: begin
          if (r_fold_left <= FW'(1)) begin
            r_out_result <= w_red_result;
            r_out_bv     <= w_red_bv;
            r_out_valid  <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_acc       <= w_fold_y;
            r_half      <= r_half >> 1;
            r_fold_left <= r_fold_left - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_byte_valid = r_out_bv;

endmodule
